// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the decoder and its code-decode stage.
// Helpers take the live width so one definition serves any WIDTH up to JW_MAX.
package johnson_pkg;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} jd_state_t;

    localparam int JW_MAX = 32;

    // Shift left, feed back the inverted MSB, clear bits above the active width.
    function automatic logic [JW_MAX-1:0] johnson_next(input logic [JW_MAX-1:0] q, input int w);
        logic [JW_MAX-1:0] nq;
        nq    = {q[JW_MAX-2:0], 1'b0};
        nq[0] = ~q[w-1];
        for (int i = 0; i < JW_MAX; i++) begin
            if (i >= w) nq[i] = 1'b0;
        end
        return nq;
    endfunction

    // Low-aligned run of k ones -> k; run of ones above j zeros (0<j<w) -> w+j.
    function automatic void johnson_decode(input logic [JW_MAX-1:0] q, input int w,
                                           output int idx, output logic ok);
        logic [JW_MAX-1:0] lo;
        logic [JW_MAX-1:0] wmask;
        idx   = 0;
        ok    = 1'b0;
        lo    = '0;
        wmask = '0;
        for (int k = 0; k <= JW_MAX; k++) begin
            if (k <= w && q == lo) begin
                idx = k;
                ok  = 1'b1;
            end
            if (k == w) wmask = lo;
            lo = {lo[JW_MAX-2:0], 1'b1};
        end
        lo = '0;
        for (int j = 1; j < JW_MAX; j++) begin
            lo = {lo[JW_MAX-2:0], 1'b1};
            if (j < w && q == (wmask & ~lo)) begin
                idx = w + j;
                ok  = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code -> index/legal decode.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             ok_o
);

    int   idx;
    logic ok;

    always_comb begin
        idx = 0;
        ok  = 1'b0;
        johnson_decode(JW_MAX'(q_i), WIDTH, idx, ok);
        idx_o = IDX_W'(idx);
        ok_o  = ok;
    end

endmodule

// File: rtl/johnson_decoder.sv
// Receive-side Johnson decoder: registered decode, successor-tracking lock FSM,
// and a saturating sequence-error counter.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int IDX_W    = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   q_in,
    input  logic               q_valid,
    output logic [IDX_W-1:0]   count,
    output logic [2*WIDTH-1:0] onehot,
    output logic               legal,
    output logic               locked,
    output logic               seq_err,
    output logic [7:0]         err_count
);

    localparam int N  = 2*WIDTH;
    localparam int MW = $clog2(LOCK_CNT+1);

    jd_state_t        state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             legal_q, legal_d;
    logic             seq_err_q, seq_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0] dec_idx, succ_idx;
    logic             dec_ok, is_succ;

    johnson_code_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
        .q_i   (q_in),
        .idx_o (dec_idx),
        .ok_o  (dec_ok)
    );

    // count_q/legal_q double as the previous-sample index and legality:
    // count only moves on legal samples, and the index matters only when legal.
    always_comb begin
        succ_idx = (count_q == IDX_W'(N-1)) ? '0 : count_q + 1'b1;
        is_succ  = dec_ok && legal_q && (dec_idx == succ_idx);
    end

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        count_d   = count_q;
        onehot_d  = onehot_q;
        legal_d   = legal_q;
        seq_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        if (q_valid) begin
            legal_d  = dec_ok;
            onehot_d = dec_ok ? ({{(N-1){1'b0}}, 1'b1} << dec_idx) : '0;
            if (dec_ok) count_d = dec_idx;
            case (state_q)
                SEARCH: begin
                    if (is_succ) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MW'(LOCK_CNT)) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (!is_succ) begin
                        seq_err_d = 1'b1;
                        match_d   = '0;
                        state_d   = SEARCH;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            match_q   <= '0;
            count_q   <= '0;
            onehot_q  <= '0;
            legal_q   <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            count_q   <= count_d;
            onehot_q  <= onehot_d;
            legal_q   <= legal_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign count     = count_q;
    assign onehot    = onehot_q;
    assign legal     = legal_q;
    assign locked    = (state_q == LOCKED);
    assign seq_err   = seq_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized + directed bench for johnson_decoder; two instances (LOCK_CNT 3 and 1)
// share one stimulus stream and are compared against a table-driven model.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       q_valid = 1'b0;

    logic [2:0] cnt0, cnt1;
    logic [7:0] oh0, oh1, e0, e1;
    logic       lg0, lg1, lk0, lk1, se0, se1;

    johnson_decoder u_dut0 (
        .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
        .count(cnt0), .onehot(oh0), .legal(lg0), .locked(lk0),
        .seq_err(se0), .err_count(e0)
    );

    johnson_decoder #(.WIDTH(4), .LOCK_CNT(1)) u_dut1 (
        .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
        .count(cnt1), .onehot(oh1), .legal(lg1), .locked(lk1),
        .seq_err(se1), .err_count(e1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int ptr = 0;

    int m_cnt[2], m_oh[2], m_lg[2], m_lk[2], m_se[2], m_err[2], m_match[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // k-th code of the 8-long sequence: fill ones from bit 0, then clear from bit 0.
    function automatic int code(input int k);
        if (k <= 4) return (1 << k) - 1;
        return 15 & ~((1 << (k - 4)) - 1);
    endfunction

    task automatic model_step(input int d, input int lc, input bit rst, input bit v, input int q);
        int  idx;
        bit  ok, succ;
        if (rst) begin
            m_cnt[d] = 0; m_oh[d] = 0; m_lg[d] = 0; m_lk[d] = 0;
            m_se[d] = 0; m_err[d] = 0; m_match[d] = 0;
            return;
        end
        m_se[d] = 0;
        if (!v) return;
        ok = 0; idx = 0;
        for (int k = 0; k < 8; k++) if (code(k) == q) begin ok = 1; idx = k; end
        succ = ok && (m_lg[d] != 0) && (idx == (m_cnt[d] + 1) % 8);
        if (m_lk[d] != 0) begin
            if (!succ) begin
                m_se[d] = 1; m_lk[d] = 0; m_match[d] = 0;
                if (m_err[d] < 255) m_err[d]++;
            end
        end else if (succ) begin
            m_match[d]++;
            if (m_match[d] >= lc) m_lk[d] = 1;
        end else begin
            m_match[d] = 0;
        end
        m_lg[d] = ok;
        m_oh[d] = ok ? (1 << idx) : 0;
        if (ok) m_cnt[d] = idx;
    endtask

    task automatic cmp_all();
        check("d0.count", 32'(cnt0), m_cnt[0]);
        check("d0.onehot", 32'(oh0), m_oh[0]);
        check("d0.legal", 32'(lg0), m_lg[0]);
        check("d0.locked", 32'(lk0), m_lk[0]);
        check("d0.seq_err", 32'(se0), m_se[0]);
        check("d0.err_count", 32'(e0), m_err[0]);
        check("d1.count", 32'(cnt1), m_cnt[1]);
        check("d1.onehot", 32'(oh1), m_oh[1]);
        check("d1.legal", 32'(lg1), m_lg[1]);
        check("d1.locked", 32'(lk1), m_lk[1]);
        check("d1.seq_err", 32'(se1), m_se[1]);
        check("d1.err_count", 32'(e1), m_err[1]);
    endtask

    // Inputs driven at negedge, outputs compared at the following negedge.
    task automatic step(input bit rst, input bit v, input int q);
        reset = rst; q_valid = v; q_in = 4'(q);
        @(posedge clk);
        model_step(0, 3, rst, v, q);
        model_step(1, 1, rst, v, q);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic send(input bit v);
        step(1'b0, v, code(ptr));
        if (v) ptr = (ptr + 1) % 8;
    endtask

    initial begin
        int r, c;
        for (int d = 0; d < 2; d++) model_step(d, 1, 1'b1, 1'b0, 0);

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 5);
        check("rst.locked", 32'(lk0), 0);

        // Free-running stream from 0000
        ptr = 0;
        for (int i = 0; i < 3; i++) send(1'b1);
        check("free.prelock", 32'(lk0), 0);
        send(1'b1);
        check("free.lock4", 32'(lk0), 1);
        for (int i = 0; i < 16; i++) send(1'b1);
        check("free.err0", 32'(e0), 0);

        // Illegal code while locked
        c = cnt0;
        step(1'b0, 1'b1, 4'b0101);
        check("ill.legal", 32'(lg0), 0);
        check("ill.onehot", 32'(oh0), 0);
        check("ill.serr", 32'(se0), 1);
        check("ill.err", 32'(e0), 1);
        check("ill.count_hold", 32'(cnt0), c);
        for (int i = 0; i < 4; i++) send(1'b1);
        check("ill.relock", 32'(lk0), 1);
        send(1'b1);
        check("ill.serr_clear", 32'(se0), 0);

        // Skipped state while locked
        step(1'b0, 1'b1, code((ptr + 1) % 8));
        ptr = (ptr + 2) % 8;
        check("skip.legal", 32'(lg0), 1);
        check("skip.serr", 32'(se0), 1);
        check("skip.err", 32'(e0), 2);
        for (int i = 0; i < 4; i++) send(1'b1);

        // Reset mid-lock, then valid gaps
        step(1'b1, 1'b1, code(ptr));
        check("rstmid.locked", 32'(lk0), 0);
        check("rstmid.err", 32'(e0), 0);
        ptr = 3;
        for (int i = 0; i < 10; i++) begin
            send(1'b1);
            send(1'b0);
        end
        check("gap.locked", 32'(lk0), 1);

        // Wrap-around 7 -> 0 exercised above; now random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(99);
            if (r < 2) begin
                step(1'b1, 1'($urandom_range(1)), int'($urandom_range(15)));
            end else begin
                r = $urandom_range(99);
                if (r < 70)      send($urandom_range(9) != 0);
                else if (r < 82) step(1'b0, 1'b1, int'($urandom_range(15)));
                else if (r < 92) step(1'b0, 1'b1, code((ptr + 7) % 8));
                else begin
                    step(1'b0, 1'b1, code((ptr + 1) % 8));
                    ptr = (ptr + 2) % 8;
                end
            end
        end

        // Saturation: successor relocks LOCK_CNT=1 instance, repeat breaks it
        step(1'b1, 1'b0, 0);
        ptr = 0;
        send(1'b1);
        for (int i = 0; i < 265; i++) begin
            send(1'b1);
            step(1'b0, 1'b1, code((ptr + 7) % 8));
        end
        check("sat.err", 32'(e1), 255);
        check("sat.serr", 32'(se1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 4-bit Johnson counter. Samples a Johnson-coded word each valid cycle, decodes it to a binary index and a one-hot vector, and checks that successive samples follow the Johnson sequence. A lock state machine reports when the incoming stream is being tracked, and a saturating counter records sequence errors. Sits downstream of any `johnson_counter` instance, for status display and self-check in benches and on-chip monitors.

## Interface
- `WIDTH`, default 4: Johnson register width; sequence length is `2*WIDTH`.
- `LOCK_CNT`, default 3: consecutive correct successor transitions required to assert `locked`.
- `IDX_W`, default `$clog2(2*WIDTH)`: width of the decoded index (derived, do not override).

Ports:
- `clk`  in  1: single clock, all logic on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `q_in`  in  WIDTH: Johnson-coded sample.
- `q_valid`  in  1: `q_in` is sampled only when this is high.
- `count`  out  IDX_W: decoded index of the last legal sample.
- `onehot`  out  2*WIDTH: `1 << count`; all zeros when the last sample was illegal.
- `legal`  out  1: last valid sample was a legal Johnson code.
- `locked`  out  1: stream is being tracked.
- `seq_err`  out  1: one-cycle pulse on a sequence error while locked.
- `err_count`  out  8: number of `seq_err` pulses, saturating at 255.

## Operation
- Sequence definition: the successor of `q` is `{q[WIDTH-2:0], ~q[WIDTH-1]}`. For WIDTH=4 the sequence is 0000→0001→0011→0111→1111→1110→1100→1000→0000, with indices 0..7.
- Legal codes:
  - A low-aligned run of k ones (k = 0..WIDTH) decodes to index k.
  - A high-aligned run of m ones with zeros below it (m = 1..WIDTH-1) decodes to index `2*WIDTH-m`.
  - Every other pattern is illegal.
- Illegal sample: `legal`=0, `onehot`=0, and `count` holds its previous value.
- The FSM has states SEARCH and LOCKED, plus a `match` counter of width `$clog2(LOCK_CNT+1)`.
- SEARCH:
  - A legal sample whose index equals `(prev_idx+1) mod 2*WIDTH` while `prev_legal`=1 increments `match`.
  - Any other valid sample sets `match` to 0.
  - When `match` reaches LOCK_CNT, the FSM moves to LOCKED.
- LOCKED:
  - A valid sample that is illegal, or is not the successor, pulses `seq_err`, increments `err_count` (if below 255), clears `match`, and returns the FSM to SEARCH.
  - A repeated identical sample also counts as an error.
- `prev_idx` and `prev_legal` update on every valid sample. When `q_valid`=0, all state holds and `seq_err`=0.
- `err_count` clears only on reset.

## Timing
- All outputs are registered. A sample taken at edge N is reflected on `count`, `onehot`, `legal`, and `seq_err` after edge N.
- `locked` rises after the edge that samples the LOCK_CNT-th correct successor. From a reset stream 0000, 0001, 0011, 0111, `locked` goes high after the 4th valid edge.
- `locked` falls after the same edge that raises `seq_err`.
- Wrap-around: index 2*WIDTH-1 → 0 is a correct successor (for WIDTH=4, 1000→0000).
- Reset values: `count`=0, `onehot`=0, `legal`=0, `locked`=0, `seq_err`=0, `err_count`=0, FSM=SEARCH, `match`=0, `prev_legal`=0.
- Reset asserted mid-stream overrides `q_valid` on that edge. The first valid sample after reset cannot count as a successor.
- An error at `err_count`=255 still pulses `seq_err` and drops lock; the count stays at 255.

## Structure
- Package `johnson_pkg` holds:
  - the state enum `jd_state_t` {SEARCH, LOCKED};
  - function `johnson_next(q)`;
  - function `johnson_decode(q, output idx, output ok)`.
- Sub-module `johnson_code_decode` is purely combinational: `q_in` → index and legal flag. It is instantiated once in `johnson_decoder`, which owns all registers and the FSM.
- A bench can check the decoder directly against a `johnson_counter` instance, with its `q` tied to `q_in` and `q_valid`=1.

## Test plan
- **Reset, then free-running counter.** Drive `q_in` from `johnson_counter` with `reset` for 1 cycle.
  - `count` tracks 0,1,…,7,0.
  - `onehot` tracks 0x01, 0x02, …, 0x80.
  - `locked`=1 after the 4th valid edge; `err_count` stays 0 over 20 cycles.
- **Illegal code while locked.** Once locked, inject 0101 for one sample.
  - `legal`=0, `onehot`=0, `seq_err` is a one-cycle pulse, `locked`=0, `err_count`=1.
  - `count` holds its old value.
  - Relock after 3 further correct successors.
- **Skipped state.** Locked at 0011, next sample 1111.
  - `legal`=1, `count`=4, `seq_err`=1, `err_count` increments.
- **`q_valid` gaps.** Send the stream with `q_valid` low on alternate cycles.
  - Lock is still acquired after 4 valid samples; no `seq_err` is raised during gaps.
- **Reset mid-lock.** Assert `reset` for one cycle while locked with `err_count`=2.
  - Next cycle: all outputs are 0 and the FSM is in SEARCH.
- **Saturation.** Force 260 alternating-error samples while toggling lock, using WIDTH=4 with LOCK_CNT=1.
  - `err_count` = 255 and holds; `seq_err` still pulses on each error.
